// File: rtl/btb_sram_port_ctrl.sv
// btb_sram_port_ctrl: single-port BTB SRAM front end with init sweep,
// one-entry write buffer, read-after-write bypass and write starvation guard.
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   io_rd_*               : predictor read request (valid/ready + set index)
//   io_resp_*             : read response, one cycle after read fire
//   io_wr_*               : update write request into the write buffer
//   sram_rreq_* / rresp_* : SRAM read port (data returns the next cycle)
//   sram_wreq_*           : SRAM write port
//   io_perf_rd_stall/io_perf_bypass : 32-bit saturating perf counters,
//                           present only with BTB_SRAM_PORT_CTRL_PERF_EN defined
module btb_sram_port_ctrl #(
    parameter int NSETS     = 128,
    parameter int IDX_W     = 7,
    parameter int TAG_W     = 9,
    parameter int CTR_W     = 2,
    parameter int TGT_W     = 39,
    parameter int MAX_STALL = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_rd_valid,
    output logic             io_rd_ready,
    input  logic [IDX_W-1:0] io_rd_setIdx,
    output logic             io_resp_valid,
    output logic [TAG_W-1:0] io_resp_tag,
    output logic [CTR_W-1:0] io_resp_ctr,
    output logic [TGT_W-1:0] io_resp_target,
    input  logic             io_wr_valid,
    output logic             io_wr_ready,
    input  logic [IDX_W-1:0] io_wr_setIdx,
    input  logic [TAG_W-1:0] io_wr_tag,
    input  logic [CTR_W-1:0] io_wr_ctr,
    input  logic [TGT_W-1:0] io_wr_target,
    output logic             sram_rreq_valid,
    output logic [IDX_W-1:0] sram_rreq_setIdx,
    input  logic [TAG_W-1:0] sram_rresp_tag,
    input  logic [CTR_W-1:0] sram_rresp_ctr,
    input  logic [TGT_W-1:0] sram_rresp_target,
    output logic             sram_wreq_valid,
    output logic [IDX_W-1:0] sram_wreq_setIdx,
    output logic [TAG_W-1:0] sram_wreq_tag,
    output logic [CTR_W-1:0] sram_wreq_ctr,
    output logic [TGT_W-1:0] sram_wreq_target
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
    ,
    output logic [31:0]      io_perf_rd_stall,
    output logic [31:0]      io_perf_bypass
`endif
);

    localparam int SC_W = $clog2(MAX_STALL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSETS - 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(MAX_STALL);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0] init_idx;

    logic             wbuf_valid;
    logic [IDX_W-1:0] wbuf_idx;
    logic [TAG_W-1:0] wbuf_tag;
    logic [CTR_W-1:0] wbuf_ctr;
    logic [TGT_W-1:0] wbuf_tgt;
    logic [SC_W-1:0]  starve_cnt;

    logic             resp_valid;
    logic             byp_hit;
    logic [TAG_W-1:0] byp_tag;
    logic [CTR_W-1:0] byp_ctr;
    logic [TGT_W-1:0] byp_tgt;

    logic force_wr;
    logic rd_fire;
    logic wr_fire;
    logic wr_issue;

    // The buffered write has lost MAX_STALL arbitrations in a row:
    // block reads for one cycle so it can drain.
    assign force_wr = wbuf_valid && (starve_cnt == STALL_MAX);

    always_comb begin
        state_nxt        = state;
        io_rd_ready      = 1'b0;
        io_wr_ready      = 1'b0;
        rd_fire          = 1'b0;
        wr_fire          = 1'b0;
        wr_issue         = 1'b0;
        sram_rreq_valid  = 1'b0;
        sram_rreq_setIdx = '0;
        sram_wreq_valid  = 1'b0;
        sram_wreq_setIdx = '0;
        sram_wreq_tag    = '0;
        sram_wreq_ctr    = '0;
        sram_wreq_target = '0;
        unique case (state)
            ST_INIT: begin
                sram_wreq_valid  = 1'b1;
                sram_wreq_setIdx = init_idx;
                if (init_idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                io_wr_ready = !wbuf_valid;
                io_rd_ready = !force_wr;
                wr_fire     = io_wr_valid && !wbuf_valid;
                rd_fire     = io_rd_valid && !force_wr;
                // Reads win the single port; a write only goes out
                // in a cycle with no read.
                if (rd_fire) begin
                    sram_rreq_valid  = 1'b1;
                    sram_rreq_setIdx = io_rd_setIdx;
                end else if (wbuf_valid) begin
                    wr_issue         = 1'b1;
                    sram_wreq_valid  = 1'b1;
                    sram_wreq_setIdx = wbuf_idx;
                    sram_wreq_tag    = wbuf_tag;
                    sram_wreq_ctr    = wbuf_ctr;
                    sram_wreq_target = wbuf_tgt;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
        end
    end

    // Write buffer: load and issue are mutually exclusive because a
    // load needs an empty buffer and an issue needs a full one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbuf_valid <= 1'b0;
            wbuf_idx   <= '0;
            wbuf_tag   <= '0;
            wbuf_ctr   <= '0;
            wbuf_tgt   <= '0;
        end else if (wr_fire) begin
            wbuf_valid <= 1'b1;
            wbuf_idx   <= io_wr_setIdx;
            wbuf_tag   <= io_wr_tag;
            wbuf_ctr   <= io_wr_ctr;
            wbuf_tgt   <= io_wr_target;
        end else if (wr_issue) begin
            wbuf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (wr_issue) begin
            starve_cnt <= '0;
        end else if (rd_fire && wbuf_valid && starve_cnt != STALL_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // The SRAM still holds the old entry while the write sits in the
    // buffer, so a read to that set takes the buffered data instead.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            byp_hit    <= 1'b0;
            byp_tag    <= '0;
            byp_ctr    <= '0;
            byp_tgt    <= '0;
        end else begin
            resp_valid <= rd_fire;
            byp_hit    <= rd_fire && wbuf_valid && (wbuf_idx == io_rd_setIdx);
            if (rd_fire) begin
                byp_tag <= wbuf_tag;
                byp_ctr <= wbuf_ctr;
                byp_tgt <= wbuf_tgt;
            end
        end
    end

    always_comb begin
        io_resp_valid  = resp_valid;
        io_resp_tag    = '0;
        io_resp_ctr    = '0;
        io_resp_target = '0;
        if (resp_valid) begin
            if (byp_hit) begin
                io_resp_tag    = byp_tag;
                io_resp_ctr    = byp_ctr;
                io_resp_target = byp_tgt;
            end else begin
                io_resp_tag    = sram_rresp_tag;
                io_resp_ctr    = sram_rresp_ctr;
                io_resp_target = sram_rresp_target;
            end
        end
    end

`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_byp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall <= '0;
        end else if (state == ST_RUN && io_rd_valid && !io_rd_ready
                     && perf_stall != '1) begin
            perf_stall <= perf_stall + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_byp <= '0;
        end else if (resp_valid && byp_hit && perf_byp != '1) begin
            perf_byp <= perf_byp + 1'b1;
        end
    end

    assign io_perf_rd_stall = perf_stall;
    assign io_perf_bypass   = perf_byp;
`endif

endmodule

// File: tb/tb_btb_sram_port_ctrl.sv
// Testbench for btb_sram_port_ctrl: directed vector table, multi-cycle
// corner sequences, and random traffic against a logical-memory model.
module tb_btb_sram_port_ctrl;

    typedef struct packed {
        logic [8:0]  tag;
        logic [1:0]  ctr;
        logic [38:0] tgt;
    } ent_t;

    typedef struct {
        logic [6:0] wset;
        ent_t       wdata;
        int         gap;
        logic [6:0] rset;
        ent_t       exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        io_rd_valid;
    logic        io_rd_ready;
    logic [6:0]  io_rd_setIdx;
    logic        io_resp_valid;
    logic [8:0]  io_resp_tag;
    logic [1:0]  io_resp_ctr;
    logic [38:0] io_resp_target;
    logic        io_wr_valid;
    logic        io_wr_ready;
    logic [6:0]  io_wr_setIdx;
    logic [8:0]  io_wr_tag;
    logic [1:0]  io_wr_ctr;
    logic [38:0] io_wr_target;
    logic        sram_rreq_valid;
    logic [6:0]  sram_rreq_setIdx;
    logic [8:0]  sram_rresp_tag;
    logic [1:0]  sram_rresp_ctr;
    logic [38:0] sram_rresp_target;
    logic        sram_wreq_valid;
    logic [6:0]  sram_wreq_setIdx;
    logic [8:0]  sram_wreq_tag;
    logic [1:0]  sram_wreq_ctr;
    logic [38:0] sram_wreq_target;
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
    logic [31:0] io_perf_rd_stall;
    logic [31:0] io_perf_bypass;
`endif

    btb_sram_port_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .io_rd_valid      (io_rd_valid),
        .io_rd_ready      (io_rd_ready),
        .io_rd_setIdx     (io_rd_setIdx),
        .io_resp_valid    (io_resp_valid),
        .io_resp_tag      (io_resp_tag),
        .io_resp_ctr      (io_resp_ctr),
        .io_resp_target   (io_resp_target),
        .io_wr_valid      (io_wr_valid),
        .io_wr_ready      (io_wr_ready),
        .io_wr_setIdx     (io_wr_setIdx),
        .io_wr_tag        (io_wr_tag),
        .io_wr_ctr        (io_wr_ctr),
        .io_wr_target     (io_wr_target),
        .sram_rreq_valid  (sram_rreq_valid),
        .sram_rreq_setIdx (sram_rreq_setIdx),
        .sram_rresp_tag   (sram_rresp_tag),
        .sram_rresp_ctr   (sram_rresp_ctr),
        .sram_rresp_target(sram_rresp_target),
        .sram_wreq_valid  (sram_wreq_valid),
        .sram_wreq_setIdx (sram_wreq_setIdx),
        .sram_wreq_tag    (sram_wreq_tag),
        .sram_wreq_ctr    (sram_wreq_ctr),
        .sram_wreq_target (sram_wreq_target)
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
        ,
        .io_perf_rd_stall (io_perf_rd_stall),
        .io_perf_bypass   (io_perf_bypass)
`endif
    );

    int errors = 0;
    int checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: registered read, starts full of garbage.
    ent_t mem [128];
    ent_t rd_q;
    bit   fill_en = 1'b1;
    bit   sram_zero = 1'b0;
    bit   watch = 1'b0;
    int   bad_wr = 0;

    always @(posedge clock) begin
        if (fill_en) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] <= ent_t'({$urandom(), $urandom()});
            end
            fill_en <= 1'b0;
        end
        if (sram_wreq_valid) begin
            mem[sram_wreq_setIdx] <= {sram_wreq_tag, sram_wreq_ctr, sram_wreq_target};
        end
        if (sram_rreq_valid) begin
            rd_q <= mem[sram_rreq_setIdx];
        end
        if (watch && sram_wreq_valid && sram_wreq_setIdx == 7'd50
            && {sram_wreq_tag, sram_wreq_ctr, sram_wreq_target} != '0) begin
            bad_wr <= bad_wr + 1;
        end
    end

    assign sram_rresp_tag    = sram_zero ? '0 : rd_q.tag;
    assign sram_rresp_ctr    = sram_zero ? '0 : rd_q.ctr;
    assign sram_rresp_target = sram_zero ? '0 : rd_q.tgt;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk(input logic [8:0] t, input logic [1:0] c,
                                input logic [38:0] g);
        ent_t e;
        e.tag = t;
        e.ctr = c;
        e.tgt = g;
        return e;
    endfunction

    function automatic ent_t resp_e();
        return mk(io_resp_tag, io_resp_ctr, io_resp_target);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_rd_valid  = 1'b0;
        io_rd_setIdx = '0;
        io_wr_valid  = 1'b0;
        io_wr_setIdx = '0;
        io_wr_tag    = '0;
        io_wr_ctr    = '0;
        io_wr_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("reset_outs", 64'({io_rd_ready, io_wr_ready, io_resp_valid,
                                sram_rreq_valid, sram_wreq_valid, sram_wreq_setIdx}),
            64'({4'b0000, 1'b1, 7'd0}));
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
        chk("reset_perf", 64'({io_perf_rd_stall, io_perf_bypass}), 64'd0);
`endif
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Called right after reset release; walks the whole sweep with
    // requests pending to prove nothing is accepted until RUN.
    task automatic check_sweep();
        io_rd_valid  = 1'b1;
        io_rd_setIdx = 7'd9;
        io_wr_valid  = 1'b1;
        io_wr_setIdx = 7'd9;
        io_wr_tag    = 9'h1;
        io_wr_ctr    = 2'd1;
        io_wr_target = 39'h1;
        for (int i = 0; i < 128; i++) begin
            #1;
            chk($sformatf("sweep%0d", i),
                64'({sram_wreq_valid, sram_wreq_setIdx, io_rd_ready, io_wr_ready,
                     sram_rreq_valid,
                     (|{sram_wreq_tag, sram_wreq_ctr, sram_wreq_target})}),
                64'({1'b1, 7'(i), 4'b0000}));
            tick();
        end
        idle_inputs();
        #1;
        chk("run_ready", 64'({io_rd_ready, io_wr_ready, sram_wreq_valid, sram_rreq_valid}),
            64'(4'b1100));
    endtask

    task automatic do_write(input logic [6:0] s, input ent_t d);
        int n;
        io_wr_valid  = 1'b1;
        io_wr_setIdx = s;
        io_wr_tag    = d.tag;
        io_wr_ctr    = d.ctr;
        io_wr_target = d.tgt;
        n = 0;
        #1;
        while (!io_wr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!io_wr_ready) begin
            chk("wr_timeout", 64'(0), 64'(1));
        end else begin
            tick();
        end
        io_wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] s, output ent_t e);
        int n;
        e = '0;
        io_rd_valid  = 1'b1;
        io_rd_setIdx = s;
        n = 0;
        #1;
        while (!io_rd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!io_rd_ready) begin
            chk("rd_timeout", 64'(0), 64'(1));
            io_rd_valid = 1'b0;
        end else begin
            tick();
            io_rd_valid = 1'b0;
            chk("resp_valid", 64'(io_resp_valid), 64'(1));
            e = resp_e();
            tick();
            chk("resp_once", 64'(io_resp_valid), 64'(0));
        end
    endtask

    vec_t vecs [6];
    ent_t logical [128];
    ent_t got;

    initial begin
        logic [31:0] s0, b0;
        int   m_buf, m_lose;
        logic [6:0] m_set;
        ent_t m_ent, pend_e;
        bit   pend, rf, wf, wi, er, ew;

        vecs[0] = '{7'd10, mk(9'h1A5, 2'd2, 39'h12_3456_789A), 2, 7'd10,
                    mk(9'h1A5, 2'd2, 39'h12_3456_789A)};
        vecs[1] = '{7'd0, mk(9'h001, 2'd1, 39'h1), 0, 7'd0, mk(9'h001, 2'd1, 39'h1)};
        vecs[2] = '{7'd127, mk(9'h1FF, 2'd3, 39'h7F_FFFF_FFFF), 2, 7'd127,
                    mk(9'h1FF, 2'd3, 39'h7F_FFFF_FFFF)};
        vecs[3] = '{7'd20, mk(9'h055, 2'd1, 39'hABC), 1, 7'd21, mk(9'h0, 2'd0, 39'h0)};
        vecs[4] = '{7'd10, mk(9'h0AA, 2'd1, 39'h55), 0, 7'd10, mk(9'h0AA, 2'd1, 39'h55)};
        vecs[5] = '{7'd64, mk(9'h123, 2'd0, 39'h42), 0, 7'd127,
                    mk(9'h1FF, 2'd3, 39'h7F_FFFF_FFFF)};

        s0 = '0;
        b0 = '0;
        do_reset();
        check_sweep();

        do_read(7'd5, got);
        chk("read5_zero", 64'(got), 64'(0));

        foreach (vecs[i]) begin
            do_write(vecs[i].wset, vecs[i].wdata);
            repeat (vecs[i].gap) tick();
            do_read(vecs[i].rset, got);
            chk($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].exp));
        end
        tick();

        // Starvation: four reads win, fifth cycle the write is forced out.
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
        s0 = io_perf_rd_stall;
        b0 = io_perf_bypass;
`endif
        do_write(7'd3, mk(9'h033, 2'd1, 39'h333));
        io_rd_valid  = 1'b1;
        io_rd_setIdx = 7'd40;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("starve_rd%0d", k),
                64'({io_rd_ready, sram_rreq_valid, sram_wreq_valid}), 64'(3'b110));
            tick();
        end
        #1;
        chk("starve_force", 64'({io_rd_ready, sram_rreq_valid, sram_wreq_valid,
                                 sram_wreq_setIdx}), 64'({3'b001, 7'd3}));
        tick();
        io_rd_valid = 1'b0;
        #1;
        chk("starve_drained", 64'({io_wr_ready, io_rd_ready}), 64'(2'b11));
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
        chk("perf_stall_d", 64'(io_perf_rd_stall - s0), 64'(1));
        chk("perf_byp_d0", 64'(io_perf_bypass - b0), 64'(0));
`endif
        tick();

        // Bypass while the write is still buffered, SRAM returns zeros.
        sram_zero = 1'b1;
        do_write(7'd7, mk(9'h0FF, 2'd3, 39'h7_7777));
        do_read(7'd7, got);
        sram_zero = 1'b0;
        chk("bypass7", 64'(got), 64'(mk(9'h0FF, 2'd3, 39'h7_7777)));
`ifdef BTB_SRAM_PORT_CTRL_PERF_EN
        chk("perf_byp_d1", 64'(io_perf_bypass - b0), 64'(1));
`endif
        tick();

        // Reset in the middle of the sweep.
        do_reset();
        repeat (60) tick();
        chk("sweep_at60", 64'(sram_wreq_setIdx), 64'(60));
        reset = 1'b1;
        #1;
        chk("sweep_restart", 64'({sram_wreq_valid, sram_wreq_setIdx}), 64'({1'b1, 7'd0}));
        tick();
        reset = 1'b0;
        check_sweep();

        // Reset with a write buffered and a response pending.
        do_write(7'd50, mk(9'h150, 2'd2, 39'h5050));
        io_rd_valid  = 1'b1;
        io_rd_setIdx = 7'd1;
        tick();
        io_rd_valid = 1'b0;
        chk("pre_rst_resp", 64'(io_resp_valid), 64'(1));
        watch = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_resp_drop", 64'({io_resp_valid, io_wr_ready}), 64'(0));
        tick();
        reset = 1'b0;
        check_sweep();
        watch = 1'b0;
        chk("rst_wbuf_lost", 64'(bad_wr), 64'(0));
        do_read(7'd50, got);
        chk("read50_zero", 64'(got), 64'(0));

        // Random traffic against a logical view of memory: every read
        // must return the most recent accepted write to its set.
        foreach (logical[i]) logical[i] = '0;
        m_buf = 0;
        m_lose = 0;
        m_set = '0;
        m_ent = '0;
        pend = 1'b0;
        pend_e = '0;
        for (int c = 0; c < 2500; c++) begin
            io_rd_valid  = ($urandom_range(0, 9) < 6);
            io_rd_setIdx = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                       : 7'($urandom_range(0, 7));
            io_wr_valid  = ($urandom_range(0, 9) < 4);
            io_wr_setIdx = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                       : 7'($urandom_range(0, 7));
            io_wr_tag    = 9'($urandom());
            io_wr_ctr    = 2'($urandom());
            io_wr_target = 39'({$urandom(), $urandom()});
            #1;
            er = !(m_buf != 0 && m_lose == 4);
            ew = (m_buf == 0);
            chk("rnd_rd_ready", 64'(io_rd_ready), 64'(er));
            chk("rnd_wr_ready", 64'(io_wr_ready), 64'(ew));
            rf = io_rd_valid && er;
            wf = io_wr_valid && ew;
            wi = (m_buf != 0) && !rf;
            chk("rnd_port", 64'({sram_rreq_valid, sram_wreq_valid}), 64'({rf, wi}));
            if (rf) begin
                chk("rnd_rset", 64'(sram_rreq_setIdx), 64'(io_rd_setIdx));
            end
            if (wi) begin
                chk("rnd_wreq", 64'({sram_wreq_setIdx, sram_wreq_tag, sram_wreq_ctr,
                                     sram_wreq_target}), 64'({m_set, m_ent}));
            end
            chk("rnd_resp_valid", 64'(io_resp_valid), 64'(pend));
            if (pend) begin
                chk("rnd_resp", 64'(resp_e()), 64'(pend_e));
            end
            pend = rf;
            if (rf) pend_e = logical[io_rd_setIdx];
            if (m_buf != 0) begin
                if (rf) begin
                    m_lose = (m_lose < 4) ? m_lose + 1 : 4;
                end else begin
                    m_buf = 0;
                    m_lose = 0;
                end
            end
            if (wf) begin
                m_buf = 1;
                m_set = io_wr_setIdx;
                m_ent = mk(io_wr_tag, io_wr_ctr, io_wr_target);
                logical[io_wr_setIdx] = m_ent;
            end
            tick();
        end
        idle_inputs();
        #1;
        chk("rnd_last_resp", 64'(io_resp_valid), 64'(pend));
        repeat (3) tick();
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("mem%0d", i), 64'(mem[i]), 64'(logical[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
